lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one RV32I data access at a time over a req/gnt/rvalid bus,
// stalling the pipeline until the access completes.
module lsu (
    input  logic        clk,
    input  logic        rstN,
    input  logic        inValid,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluOut,
    input  logic [31:0] r2,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        ldValid,
    output logic        memErr,
    output logic        dReq,
    output logic [31:0] dAddr,
    output logic        dWe,
    output logic [3:0]  dBe,
    output logic [31:0] dWdata,
    input  logic        dGnt,
    input  logic        dRvalid,
    input  logic [31:0] dRdata
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] load_q;
    logic        ldvalid_q;
    logic        memerr_q;

    logic        accept;
    logic        legal_f3;
    logic        misalign;
    logic        go;
    logic        err;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        accept = (state_q == StIdle) && inValid && (memRead || memWrite);
        legal_f3 = 1'b0;
        if (memRead) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
                default:                                legal_f3 = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
                default:                legal_f3 = 1'b0;
            endcase
        end
        misalign = ((funct3[1:0] == 2'b01) && aluOut[0])
                || ((funct3[1:0] == 2'b10) && (aluOut[1:0] != 2'b00));
        go  = accept && legal_f3 && !misalign;
        err = accept && !(legal_f3 && !misalign);
    end

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << aluOut[1:0];
                st_wdata = {4{r2[7:0]}};
            end
            2'b01: begin
                st_be    = aluOut[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{r2[15:0]}};
            end
            2'b10: begin
                st_be    = 4'b1111;
                st_wdata = r2;
            end
            default: begin
                st_be    = 4'b0000;
                st_wdata = 32'h0;
            end
        endcase
    end

    // Lane select uses the byte offset captured at accept, not the live address.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dRdata[7:0];
            2'd1:    ld_byte = dRdata[15:8];
            2'd2:    ld_byte = dRdata[23:16];
            default: ld_byte = dRdata[31:24];
        endcase
        ld_half = off_q[1] ? dRdata[31:16] : dRdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dRdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (go) state_d = StReq;
            StReq:   if (dGnt) state_d = we_q ? StDone : StResp;
            StResp:  if (dRvalid) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= StIdle;
            addr_q    <= 32'h0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            load_q    <= 32'h0;
            ldvalid_q <= 1'b0;
            memerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ldvalid_q <= (state_q == StResp) && dRvalid;
            memerr_q  <= err;
            if (go) begin
                addr_q <= {aluOut[31:2], 2'b00};
                f3_q   <= funct3;
                off_q  <= aluOut[1:0];
                if (memRead) begin
                    we_q    <= 1'b0;
                    be_q    <= 4'b0000;
                    wdata_q <= 32'h0;
                end else begin
                    we_q    <= 1'b1;
                    be_q    <= st_be;
                    wdata_q <= st_wdata;
                end
            end
            if ((state_q == StResp) && dRvalid) begin
                load_q <= ld_ext;
            end
        end
    end

    always_comb begin
        stall    = rstN && (go || (state_q == StReq) || (state_q == StResp));
        dReq     = (state_q == StReq);
        dAddr    = addr_q;
        dWe      = we_q;
        dBe      = be_q;
        dWdata   = wdata_q;
        loadData = load_q;
        ldValid  = ldvalid_q;
        memErr   = memerr_q;
    end

endmodule
